// File: rtl/fft_pkg.sv
// Shared constants, packed complex type, FSM states and ROM helpers for the 16-point inverse FFT.
// Pure declarations: no latency, no flow control.
package fft_pkg;

    localparam int N     = 16;
    localparam int LOG2N = 4;
    localparam int CW    = 8;

    // Q1.7 components: real in the upper byte, imag in the lower byte.
    typedef struct packed {
        logic [CW-1:0] re;
        logic [CW-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        CALC = 2'd1,
        DUMP = 2'd2
    } state_t;

    // exp(+j*2*pi*k/16) scaled by 127 and rounded.
    function automatic cplx_t twiddle_inv(input logic [2:0] k);
        cplx_t w;
        case (k)
            3'd0:    w = 16'h7F00;
            3'd1:    w = 16'h7531;
            3'd2:    w = 16'h5A5A;
            3'd3:    w = 16'h3175;
            3'd4:    w = 16'h007F;
            3'd5:    w = 16'hCF75;
            3'd6:    w = 16'hA65A;
            3'd7:    w = 16'h8B31;
            default: w = 16'h7F00;
        endcase
        return w;
    endfunction

    function automatic logic [LOG2N-1:0] bitrev4(input logic [LOG2N-1:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

endpackage

// File: rtl/ifft16_core_if.sv
// Bin input stream, sample output stream and busy flag of the inverse FFT core.
// slave is the core side, master is the producer/consumer side.
interface ifft16_core_if;
    import fft_pkg::*;

    cplx_t in_data;
    logic  in_valid;
    logic  in_ready;
    cplx_t out_data;
    logic  out_valid;
    logic  out_ready;
    logic  out_last;
    logic  busy;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last, busy
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last, busy
    );

endinterface

// File: rtl/ifft16_core_ibfu.sv
// Combinational decimation-in-frequency inverse butterfly: o1=(a+b)/2, o2=((a-b)*w)/2 in Q1.7.
// Zero latency, no flow control.
module ibfu
    import fft_pkg::*;
(
    input  cplx_t a,
    input  cplx_t b,
    input  cplx_t w,
    output cplx_t o1,
    output cplx_t o2
);

    logic signed [CW:0]       sr, si, dr, di;
    logic signed [2*CW+1:0]   drx, dix, wrx, wix, pr, pi;
    logic                     unused_bits;

    always_comb begin
        sr  = {a.re[CW-1], a.re} + {b.re[CW-1], b.re};
        si  = {a.im[CW-1], a.im} + {b.im[CW-1], b.im};
        dr  = {a.re[CW-1], a.re} - {b.re[CW-1], b.re};
        di  = {a.im[CW-1], a.im} - {b.im[CW-1], b.im};
        drx = {{(CW+1){dr[CW]}}, dr};
        dix = {{(CW+1){di[CW]}}, di};
        wrx = {{(CW+2){w.re[CW-1]}}, w.re};
        wix = {{(CW+2){w.im[CW-1]}}, w.im};
        pr  = drx * wrx - dix * wix;
        pi  = drx * wix + dix * wrx;
        // >>>1 on the sum, >>>8 on the Q1.7 product: both branches are halved.
        o1  = {sr[CW:1], si[CW:1]};
        o2  = {pr[2*CW-1:CW], pi[2*CW-1:CW]};
    end

    assign unused_bits = ^{sr[0], si[0], pr[2*CW+1:2*CW], pr[CW-1:0], pi[2*CW+1:2*CW], pi[CW-1:0]};

endmodule

// File: rtl/ifft16_core.sv
// 16-point in-place radix-2 inverse FFT: load 16 bins, 32 butterfly cycles, dump 16 samples in natural order.
// Latency: first sample one cycle after the 32nd butterfly; minimum frame period 64 cycles.
// Backpressure: in_ready low outside LOAD; out_data/out_last hold while out_valid and !out_ready.
module ifft16_core
    import fft_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    ifft16_core_if.slave  bus
);

    state_t           state, nstate;
    cplx_t            mem [N];
    logic [LOG2N-1:0] cnt;
    logic [1:0]       stg;
    logic [2:0]       bf;
    logic             busy_q;
    logic [LOG2N-1:0] ia, ja;
    logic [2:0]       tk;
    cplx_t            tw, bo1, bo2;
    logic             in_fire, out_fire, calc_done;

    // Pair addressing: span = 8>>stg, twiddle exponent scales by 2^stg.
    always_comb begin
        ia = '0;
        ja = '0;
        tk = '0;
        case (stg)
            2'd0: begin ia = {1'b0, bf};               ja = {1'b1, bf};               tk = bf;               end
            2'd1: begin ia = {bf[2], 1'b0, bf[1:0]};   ja = {bf[2], 1'b1, bf[1:0]};   tk = {bf[1:0], 1'b0};  end
            2'd2: begin ia = {bf[2:1], 1'b0, bf[0]};   ja = {bf[2:1], 1'b1, bf[0]};   tk = {bf[0], 2'b00};   end
            2'd3: begin ia = {bf, 1'b0};               ja = {bf, 1'b1};               tk = 3'd0;             end
            default: ;
        endcase
    end

    assign tw = twiddle_inv(tk);

    ibfu u_bfu (
        .a  (mem[ia]),
        .b  (mem[ja]),
        .w  (tw),
        .o1 (bo1),
        .o2 (bo2)
    );

    assign in_fire   = bus.in_valid && (state == LOAD);
    assign out_fire  = bus.out_ready && (state == DUMP);
    assign calc_done = (state == CALC) && (stg == 2'd3) && (bf == 3'd7);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= nstate;
    end

    always_comb begin
        nstate        = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = '0;
        bus.busy      = busy_q;
        case (state)
            LOAD: begin
                bus.in_ready = 1'b1;
                if (in_fire && cnt == 4'd15) nstate = CALC;
            end
            CALC: begin
                if (calc_done) nstate = DUMP;
            end
            DUMP: begin
                bus.out_valid = 1'b1;
                bus.out_last  = (cnt == 4'd15);
                bus.out_data  = mem[bitrev4(cnt)];
                if (out_fire && cnt == 4'd15) nstate = LOAD;
            end
            default: nstate = LOAD;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            stg    <= '0;
            bf     <= '0;
            busy_q <= 1'b0;
            for (int n = 0; n < N; n++) mem[n] <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        mem[cnt] <= bus.in_data;
                        cnt      <= cnt + 4'd1;
                        busy_q   <= 1'b1;
                        if (cnt == 4'd15) begin
                            stg <= '0;
                            bf  <= '0;
                        end
                    end
                end
                CALC: begin
                    // Pairs within a stage are disjoint, so both writes land on one edge.
                    mem[ia]   <= bo1;
                    mem[ja]   <= bo2;
                    {stg, bf} <= {stg, bf} + 5'd1;
                    if (calc_done) cnt <= '0;
                end
                DUMP: begin
                    if (out_fire) begin
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) busy_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ifft16_core.sv
// Self-checking bench for ifft16_core: directed spectra plus random frames against a textbook DIF model.
module tb_ifft16_core;

    logic clk, rst;
    int   errors, checks;
    int   cyc;

    ifft16_core_if bus();

    ifft16_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    function automatic int wrap8(input int v);
        logic [7:0] b;
        b = v[7:0];
        return int'($signed(b));
    endfunction

    // Radix-2 DIF inverse FFT over the whole array, stage by stage, then bit-reversed read-out.
    task automatic model(input logic [15:0] x [16], output logic [15:0] y [16]);
        int re [16];
        int im [16];
        int wr_t [8];
        int wi_t [8];
        int span, i, j, t, sr, si, dr, di, r;
        logic [7:0] yr, yi;
        wr_t = '{127, 117, 90, 49, 0, -49, -90, -117};
        wi_t = '{0, 49, 90, 117, 127, 117, 90, 49};
        for (int k = 0; k < 16; k++) begin
            re[k] = wrap8(int'(x[k][15:8]));
            im[k] = wrap8(int'(x[k][7:0]));
        end
        for (int s = 0; s < 4; s++) begin
            span = 8 >> s;
            for (int base = 0; base < 16; base += 2 * span) begin
                for (int m = 0; m < span; m++) begin
                    i  = base + m;
                    j  = i + span;
                    t  = m << s;
                    sr = re[i] + re[j];
                    si = im[i] + im[j];
                    dr = re[i] - re[j];
                    di = im[i] - im[j];
                    re[i] = wrap8(sr >>> 1);
                    im[i] = wrap8(si >>> 1);
                    re[j] = wrap8((dr * wr_t[t] - di * wi_t[t]) >>> 8);
                    im[j] = wrap8((dr * wi_t[t] + di * wr_t[t]) >>> 8);
                end
            end
        end
        for (int n = 0; n < 16; n++) begin
            r  = ((n & 1) << 3) | ((n & 2) << 1) | ((n & 4) >> 1) | ((n & 8) >> 3);
            yr = re[r][7:0];
            yi = im[r][7:0];
            y[n] = {yr, yi};
        end
    endtask

    task automatic send_frame(input logic [15:0] x [16], input int gap, output logic bsy1, output bit ok);
        int to;
        ok   = 1'b1;
        bsy1 = 1'b0;
        for (int k = 0; k < 16; k++) begin
            if (gap > 0 && k > 0) begin
                bus.in_valid = 1'b0;
                repeat (gap) @(negedge clk);
            end
            bus.in_valid = 1'b1;
            bus.in_data  = x[k];
            to = 0;
            while (!bus.in_ready && to < 300) begin
                @(negedge clk);
                to++;
            end
            if (!bus.in_ready) begin
                ok = 1'b0;
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge clk);
            if (k == 0) bsy1 = bus.busy;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic recv_frame(input bit stall, output logic [15:0] d [16], output logic lst [16],
                              output int wait_cyc, output int hold_err, output int rdy_err, output bit ok);
        int idx, guard;
        bit prev_hold;
        logic [15:0] pd;
        logic pl;
        bit rd;
        ok = 1'b1; hold_err = 0; rdy_err = 0; wait_cyc = 0;
        pd = '0; pl = 1'b0; prev_hold = 1'b0;
        for (int n = 0; n < 16; n++) begin d[n] = 'x; lst[n] = 1'bx; end
        bus.out_ready = 1'b0;
        while (!bus.out_valid && wait_cyc < 200) begin
            @(negedge clk);
            wait_cyc++;
        end
        if (!bus.out_valid) begin
            ok = 1'b0;
            return;
        end
        idx = 0; guard = 0;
        while (idx < 16 && guard < 2000) begin
            if (!bus.out_valid || bus.in_ready) rdy_err++;
            if (prev_hold && (bus.out_data !== pd || bus.out_last !== pl)) hold_err++;
            rd = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.out_ready = rd;
            if (rd) begin
                d[idx]    = bus.out_data;
                lst[idx]  = bus.out_last;
                idx++;
                prev_hold = 1'b0;
            end else begin
                pd        = bus.out_data;
                pl        = bus.out_last;
                prev_hold = 1'b1;
            end
            @(negedge clk);
            guard++;
        end
        bus.out_ready = 1'b0;
        if (idx < 16) ok = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0)   begin errors++; $display("FAIL reset_out_last got=%b want=0", bus.out_last); end
        checks++; if (bus.busy !== 1'b0)       begin errors++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
        checks++; if (bus.out_data !== 16'h0)  begin errors++; $display("FAIL reset_out_data got=%h want=0000", bus.out_data); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1)   begin errors++; $display("FAIL post_reset_in_ready got=%b want=1", bus.in_ready); end
    endtask

    task automatic test_impulse;
        logic [15:0] x [16];
        logic [15:0] d [16];
        logic lst [16];
        logic b1; bit ok, rok; int wc, he, re;
        for (int k = 0; k < 16; k++) x[k] = 16'h0000;
        x[0] = 16'h7F00;
        send_frame(x, 0, b1, ok);
        checks++; if (!ok)             begin errors++; $display("FAIL impulse_load got=timeout want=accepted"); end
        checks++; if (b1 !== 1'b1)     begin errors++; $display("FAIL impulse_busy_rise got=%b want=1", b1); end
        recv_frame(1'b0, d, lst, wc, he, re, rok);
        checks++; if (!rok)            begin errors++; $display("FAIL impulse_dump got=timeout want=16 samples"); end
        checks++; if (wc != 32)        begin errors++; $display("FAIL impulse_calc_latency got=%0d want=32", wc); end
        for (int n = 0; n < 16; n++) begin
            checks++; if (d[n] !== 16'h0700) begin errors++; $display("FAIL impulse_x%0d got=%h want=0700", n, d[n]); end
            checks++; if (lst[n] !== (n == 15)) begin errors++; $display("FAIL impulse_last%0d got=%b want=%b", n, lst[n], n == 15); end
        end
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
            begin errors++; $display("FAIL impulse_after got=ready%b busy%b want=ready1 busy0", bus.in_ready, bus.busy); end
    endtask

    task automatic test_dc;
        logic [15:0] x [16];
        logic [15:0] d [16];
        logic lst [16];
        logic b1; bit ok, rok; int wc, he, re;
        logic [15:0] exp_v;
        for (int k = 0; k < 16; k++) x[k] = 16'h4000;
        send_frame(x, 0, b1, ok);
        recv_frame(1'b0, d, lst, wc, he, re, rok);
        checks++; if (!ok || !rok) begin errors++; $display("FAIL dc_handshake got=load%0b dump%0b want=11", ok, rok); end
        for (int n = 0; n < 16; n++) begin
            exp_v = (n == 0) ? 16'h4000 : 16'h0000;
            checks++; if (d[n] !== exp_v) begin errors++; $display("FAIL dc_x%0d got=%h want=%h", n, d[n], exp_v); end
        end
    endtask

    task automatic test_single_bin;
        logic [15:0] x [16];
        logic [15:0] y [16];
        logic [15:0] d [16];
        logic lst [16];
        logic b1; bit ok, rok; int wc, he, re;
        int x0r, x4r, x4i;
        logic [7:0] t8;
        for (int k = 0; k < 16; k++) x[k] = 16'h0000;
        x[1] = 16'h7F00;
        model(x, y);
        send_frame(x, 0, b1, ok);
        recv_frame(1'b0, d, lst, wc, he, re, rok);
        checks++; if (!ok || !rok) begin errors++; $display("FAIL bin1_handshake got=load%0b dump%0b want=11", ok, rok); end
        for (int n = 0; n < 16; n++) begin
            checks++; if (d[n] !== y[n]) begin errors++; $display("FAIL bin1_x%0d got=%h want=%h", n, d[n], y[n]); end
        end
        t8 = d[0][15:8]; x0r = int'($signed(t8));
        t8 = d[4][15:8]; x4r = int'($signed(t8));
        t8 = d[4][7:0];  x4i = int'($signed(t8));
        checks++; if (x0r < 7 || x0r > 8)  begin errors++; $display("FAIL bin1_x0_real got=%0d want=7..8", x0r); end
        checks++; if (x4r < -1 || x4r > 1) begin errors++; $display("FAIL bin1_x4_real got=%0d want=-1..1", x4r); end
        checks++; if (x4i < 6 || x4i > 8)  begin errors++; $display("FAIL bin1_x4_imag got=%0d want=6..8", x4i); end
    endtask

    task automatic test_random_frames;
        logic [15:0] x [16];
        logic [15:0] y [16];
        logic [15:0] d [16];
        logic lst [16];
        logic b1; bit ok, rok; int wc, he, re;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < 16; k++) x[k] = 16'($urandom);
            model(x, y);
            send_frame(x, 0, b1, ok);
            recv_frame(1'b0, d, lst, wc, he, re, rok);
            checks++; if (!ok || !rok) begin errors++; $display("FAIL rand%0d_handshake got=load%0b dump%0b want=11", f, ok, rok); end
            for (int n = 0; n < 16; n++) begin
                checks++; if (d[n] !== y[n]) begin errors++; $display("FAIL rand%0d_x%0d got=%h want=%h", f, n, d[n], y[n]); end
            end
        end
    endtask

    task automatic test_backpressure;
        logic [15:0] x [16];
        logic [15:0] y [16];
        logic [15:0] d [16];
        logic lst [16];
        logic b1; bit ok, rok; int wc, he, re;
        for (int k = 0; k < 16; k++) x[k] = 16'($urandom);
        model(x, y);
        send_frame(x, 0, b1, ok);
        recv_frame(1'b1, d, lst, wc, he, re, rok);
        checks++; if (!ok || !rok) begin errors++; $display("FAIL bp_handshake got=load%0b dump%0b want=11", ok, rok); end
        checks++; if (he != 0) begin errors++; $display("FAIL bp_hold got=%0d changes want=0", he); end
        checks++; if (re != 0) begin errors++; $display("FAIL bp_ready_valid got=%0d bad cycles want=0", re); end
        for (int n = 0; n < 16; n++) begin
            checks++; if (d[n] !== y[n]) begin errors++; $display("FAIL bp_x%0d got=%h want=%h", n, d[n], y[n]); end
            checks++; if (lst[n] !== (n == 15)) begin errors++; $display("FAIL bp_last%0d got=%b want=%b", n, lst[n], n == 15); end
        end
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0)
            begin errors++; $display("FAIL bp_after got=ready%b busy%b want=ready1 busy0", bus.in_ready, bus.busy); end
    endtask

    task automatic test_input_gaps;
        logic [15:0] x [16];
        logic [15:0] y [16];
        logic [15:0] d [16];
        logic lst [16];
        logic b1; bit ok, rok; int wc, he, re;
        for (int k = 0; k < 16; k++) x[k] = 16'($urandom);
        model(x, y);
        send_frame(x, 3, b1, ok);
        checks++; if (!ok) begin errors++; $display("FAIL gap_load got=timeout want=accepted"); end
        checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0)
            begin errors++; $display("FAIL gap_calc_start got=ready%b valid%b want=ready0 valid0", bus.in_ready, bus.out_valid); end
        recv_frame(1'b0, d, lst, wc, he, re, rok);
        checks++; if (wc != 32) begin errors++; $display("FAIL gap_calc_latency got=%0d want=32", wc); end
        for (int n = 0; n < 16; n++) begin
            checks++; if (d[n] !== y[n]) begin errors++; $display("FAIL gap_x%0d got=%h want=%h", n, d[n], y[n]); end
        end
    endtask

    task automatic test_reset_mid_calc;
        logic [15:0] x [16];
        logic [15:0] y [16];
        logic [15:0] d [16];
        logic lst [16];
        logic b1; bit ok, rok; int wc, he, re, seen;
        for (int k = 0; k < 16; k++) x[k] = 16'($urandom);
        send_frame(x, 0, b1, ok);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got=%b want=1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL midrst_busy got=%b want=0", bus.busy); end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL midrst_no_output got=%0d valid cycles want=0", seen); end
        for (int k = 0; k < 16; k++) x[k] = 16'($urandom);
        model(x, y);
        send_frame(x, 0, b1, ok);
        recv_frame(1'b0, d, lst, wc, he, re, rok);
        checks++; if (!ok || !rok) begin errors++; $display("FAIL midrst_clean_handshake got=load%0b dump%0b want=11", ok, rok); end
        for (int n = 0; n < 16; n++) begin
            checks++; if (d[n] !== y[n]) begin errors++; $display("FAIL midrst_x%0d got=%h want=%h", n, d[n], y[n]); end
        end
    endtask

    task automatic test_back_to_back;
        logic [15:0] x [16];
        logic [15:0] y [16];
        logic [15:0] d [16];
        logic lst [16];
        logic b1; bit ok, rok; int wc, he, re, c0, per;
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < 16; k++) x[k] = 16'($urandom);
            model(x, y);
            c0 = cyc;
            send_frame(x, 0, b1, ok);
            recv_frame(1'b0, d, lst, wc, he, re, rok);
            per = cyc - c0;
            checks++; if (per != 64) begin errors++; $display("FAIL b2b%0d_period got=%0d want=64", f, per); end
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b%0d_ready got=%b want=1", f, bus.in_ready); end
            for (int n = 0; n < 16; n++) begin
                checks++; if (d[n] !== y[n]) begin errors++; $display("FAIL b2b%0d_x%0d got=%h want=%h", f, n, d[n], y[n]); end
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_impulse();
        test_dc();
        test_single_bin();
        test_random_frames();
        test_backpressure();
        test_input_gaps();
        test_reset_mid_calc();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
